// File: rtl/apb_mem_slave_p.sv
// apb_mem_slave_p: parametrised APB memory-mapped slave (DEPTH words of DATA_W bits)
// with programmable wait states and PSLVERR on out-of-range or misaligned accesses.
// Define APB_SLV_PSTRB_EN to add the PSTRB port and byte-lane write strobes.
module apb_mem_slave_p #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 16,
   parameter int WAIT_STATES = 0
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic [DATA_W-1:0] PWDATA,
`ifdef APB_SLV_PSTRB_EN
   input  logic [DATA_W/8-1:0] PSTRB,
`endif
   output logic [DATA_W-1:0] PRDATA,
   output logic              PREADY,
   output logic              PSLVERR
);

   localparam int NB = DATA_W / 8;
   localparam int BL = $clog2(NB);
   localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << BL) - 1);
   localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]        state;
   logic [3:0]        cnt;
   logic              wr_q;
   logic              err_q;
   logic [MW-1:0]     idx_q;
   logic [DATA_W-1:0] wdata_q;
   logic [NB-1:0]     strb_q;
   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] idx_in;
   logic              err_in;
   logic              setup;
   logic [NB-1:0]     strb_in;
   logic              enter_done;
   logic              e_wr;
   logic              e_err;
   logic [MW-1:0]     e_idx;

`ifdef APB_SLV_PSTRB_EN
   assign strb_in = PSTRB;
`else
   assign strb_in = '1;
`endif

   // Setup-cycle decode, and the transfer attributes used when entering DONE.
   // With zero wait states DONE is entered straight from IDLE, so the live bus is used.
   always_comb begin
      idx_in     = PADDR >> BL;
      err_in     = (idx_in >= DEPTH_A) | ((PADDR & LOW_MASK) != '0);
      setup      = PSEL & ~PENABLE;
      enter_done = 1'b0;
      e_wr       = wr_q;
      e_err      = err_q;
      e_idx      = idx_q;
      if (state == IDLE) begin
         enter_done = setup && (WAIT_STATES == 0);
         e_wr       = PWRITE;
         e_err      = err_in;
         e_idx      = idx_in[MW-1:0];
      end else if (state == WAIT) begin
         enter_done = PSEL && (cnt == 4'd1);
      end
   end

   // Transfer FSM, latched request and registered APB response outputs.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state   <= IDLE;
         cnt     <= '0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         strb_q  <= '0;
         PRDATA  <= '0;
         PREADY  <= 1'b0;
         PSLVERR <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (setup) begin
                  wr_q    <= PWRITE;
                  err_q   <= err_in;
                  idx_q   <= idx_in[MW-1:0];
                  wdata_q <= PWDATA;
                  strb_q  <= strb_in;
                  if (WAIT_STATES == 0) begin
                     state <= DONE;
                  end else begin
                     state <= WAIT;
                     cnt   <= 4'(WAIT_STATES);
                  end
               end
            end
            WAIT: begin
               if (!PSEL) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - 4'd1;
                  if (cnt == 4'd1) state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
         PREADY  <= enter_done;
         PSLVERR <= enter_done & e_err;
         if (enter_done) begin
            if (e_err)      PRDATA <= '0;
            else if (!e_wr) PRDATA <= mem[e_idx];
         end
      end
   end

   // Memory array: cleared by reset, written on the DONE exit edge of a good write.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if ((state == DONE) && wr_q && !err_q) begin
         for (int unsigned b = 0; b < NB; b++) begin
            if (strb_q[b]) mem[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
         end
      end
   end

endmodule

// File: tb/tb_apb_mem_slave_p.sv
// Testbench for apb_mem_slave_p: three instances (0, 3 and 2 wait states) checked
// every cycle against a transaction-level memory model kept in the bench.
`timescale 1ns/1ps
module tb_apb_mem_slave_p;

   localparam int ND = 3;
   localparam int WS_T [ND] = '{0, 3, 2};

   logic        clk = 1'b0;
   logic        rst_n;
   logic        psel    [ND];
   logic        penable [ND];
   logic        pwrite  [ND];
   logic [31:0] paddr   [ND];
   logic [31:0] pwdata  [ND];
   logic [3:0]  pstrb   [ND];
   logic [31:0] prdata  [ND];
   logic        pready  [ND];
   logic        pslverr [ND];

   logic [31:0] mem_m  [ND][16];
   logic        exp_rdy [ND];
   logic        exp_err [ND];
   logic [31:0] exp_rd  [ND];
   logic        chk_en;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      apb_mem_slave_p #(
         .ADDR_W(32), .DATA_W(32), .DEPTH(16), .WAIT_STATES(WS_T[g])
      ) u_dut (
         .PCLK(clk), .PRESETn(rst_n),
         .PSEL(psel[g]), .PENABLE(penable[g]), .PWRITE(pwrite[g]),
         .PADDR(paddr[g]), .PWDATA(pwdata[g]),
`ifdef APB_SLV_PSTRB_EN
         .PSTRB(pstrb[g]),
`endif
         .PRDATA(prdata[g]), .PREADY(pready[g]), .PSLVERR(pslverr[g])
      );
   end

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp, $time);
      end
   endtask

   // Every cycle, every instance: outputs must equal the model's expectation.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < ND; d++) begin
            chk("pready", d, 32'(pready[d]), 32'(exp_rdy[d]));
            chk("pslverr", d, 32'(pslverr[d]), 32'(exp_err[d]));
            chk("prdata", d, prdata[d], exp_rd[d]);
         end
      end
   end

   function automatic void clear_model();
      for (int d = 0; d < ND; d++) begin
         for (int w = 0; w < 16; w++) mem_m[d][w] = '0;
         exp_rdy[d] = 1'b0;
         exp_err[d] = 1'b0;
         exp_rd[d]  = '0;
      end
   endfunction

   // One APB transfer; abort_k >= 0 drops PSEL in that wait cycle.
   // Returns what the DUT showed in the cycle where PREADY first rose.
   task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb, input int abort_k,
                       output logic seen, output logic [31:0] ardata,
                       output logic aerr, output int alat);
      int          ws_n;
      int          idx;
      logic        merr;
      logic [3:0]  eff;
      ws_n = WS_T[d];
      idx  = int'(addr >> 2);
      merr = ((addr >> 2) >= 32'd16) || (addr[1:0] != 2'b00);
`ifdef APB_SLV_PSTRB_EN
      eff = strb;
`else
      eff = 4'hF;
`endif
      seen = 1'b0; ardata = '0; aerr = 1'b0; alat = 0;
      @(posedge clk); #1;
      exp_rdy[d] = 1'b0; exp_err[d] = 1'b0;
      psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
      paddr[d] = addr; pwdata[d] = data; pstrb[d] = strb;
      @(posedge clk); #1;
      penable[d] = 1'b1;
      for (int k = 0; k <= ws_n; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         if (pready[d] && !seen) begin
            seen = 1'b1; ardata = prdata[d]; aerr = pslverr[d]; alat = k;
         end
         if (k < ws_n) begin
            exp_rdy[d] = 1'b0; exp_err[d] = 1'b0;
            if (k == abort_k) begin
               psel[d] = 1'b0; penable[d] = 1'b0;
               @(posedge clk); #1;
               exp_rdy[d] = 1'b0; exp_err[d] = 1'b0;
               return;
            end
         end else begin
            exp_rdy[d] = 1'b1;
            exp_err[d] = merr;
            if (merr)     exp_rd[d] = '0;
            else if (!wr) exp_rd[d] = mem_m[d][idx];
            psel[d] = 1'b0; penable[d] = 1'b0;
            @(posedge clk); #1;
            exp_rdy[d] = 1'b0; exp_err[d] = 1'b0;
            if (wr && !merr) begin
               for (int b = 0; b < 4; b++)
                  if (eff[b]) mem_m[d][idx][b*8 +: 8] = data[b*8 +: 8];
            end
         end
      end
   endtask

   initial begin
      logic        s, e;
      logic [31:0] rd, a;
      int          lat, ab;
      logic [31:0] exp5;

      rst_n  = 1'b0;
      chk_en = 1'b0;
      for (int d = 0; d < ND; d++) begin
         psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
         paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
      end
      clear_model();
      repeat (2) @(posedge clk);
      #1 chk_en = 1'b1;
      @(posedge clk); #1 rst_n = 1'b1;
      chk("rst_pready", 0, 32'(pready[0]), 32'd0);
      chk("rst_prdata", 1, prdata[1], 32'd0);

      // Zero wait states: write then read back
      xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, -1, s, rd, e, lat);
      chk("t2_wr_lat", 0, 32'(lat), 32'd0);
      xfer(0, 1'b0, 32'h08, 32'h0, 4'hF, -1, s, rd, e, lat);
      chk("t2_rd_seen", 0, 32'(s), 32'd1);
      chk("t2_rd_lat", 0, 32'(lat), 32'd0);
      chk("t2_rd_data", 0, rd, 32'hDEADBEEF);
      chk("t2_rd_err", 0, 32'(e), 32'd0);

      // Three wait states
      xfer(1, 1'b1, 32'h04, 32'hCAFEF00D, 4'hF, -1, s, rd, e, lat);
      xfer(1, 1'b0, 32'h04, 32'h0, 4'hF, -1, s, rd, e, lat);
      chk("t3_rd_lat", 1, 32'(lat), 32'd3);
      chk("t3_rd_data", 1, rd, 32'hCAFEF00D);

      // Bad accesses: out of range and misaligned
      xfer(0, 1'b1, 32'h00, 32'h12345678, 4'hF, -1, s, rd, e, lat);
      xfer(0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, -1, s, rd, e, lat);
      chk("t4_range_seen", 0, 32'(s), 32'd1);
      chk("t4_range_err", 0, 32'(e), 32'd1);
      xfer(0, 1'b1, 32'h02, 32'hFFFFFFFF, 4'hF, -1, s, rd, e, lat);
      chk("t4_misal_err", 0, 32'(e), 32'd1);
      chk("t4_misal_data", 0, rd, 32'd0);
      xfer(0, 1'b0, 32'h00, 32'h0, 4'hF, -1, s, rd, e, lat);
      chk("t4_rd0_data", 0, rd, 32'h12345678);
      chk("t4_rd0_err", 0, 32'(e), 32'd0);

      // Byte strobes
      xfer(0, 1'b1, 32'h14, 32'h11223344, 4'hF, -1, s, rd, e, lat);
      xfer(0, 1'b1, 32'h14, 32'hAABBCCDD, 4'b0101, -1, s, rd, e, lat);
      xfer(0, 1'b0, 32'h14, 32'h0, 4'hF, -1, s, rd, e, lat);
`ifdef APB_SLV_PSTRB_EN
      exp5 = 32'h11BB33DD;
`else
      exp5 = 32'hAABBCCDD;
`endif
      chk("t5_strb_data", 0, rd, exp5);
`ifdef APB_SLV_PSTRB_EN
      xfer(0, 1'b1, 32'h14, 32'h99999999, 4'b0000, -1, s, rd, e, lat);
      xfer(0, 1'b0, 32'h14, 32'h0, 4'hF, -1, s, rd, e, lat);
      chk("t5_strb0_data", 0, rd, 32'h11BB33DD);
`endif

      // Abort during wait states
      xfer(2, 1'b1, 32'h0C, 32'h5A5A5A5A, 4'hF, -1, s, rd, e, lat);
      xfer(2, 1'b1, 32'h0C, 32'hFFFFFFFF, 4'hF, 1, s, rd, e, lat);
      chk("t6_abort_seen", 2, 32'(s), 32'd0);
      xfer(2, 1'b0, 32'h0C, 32'h0, 4'hF, -1, s, rd, e, lat);
      chk("t6_rd_data", 2, rd, 32'h5A5A5A5A);
      chk("t6_rd_lat", 2, 32'(lat), 32'd2);

      // Randomised traffic on every instance
      for (int d = 0; d < ND; d++) begin
         for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 9))
               0:       a = ($urandom_range(0, 15) << 2) | 32'($urandom_range(1, 3));
               1:       a = 32'h40 + ($urandom_range(0, 15) << 2);
               2:       a = $urandom | 32'h8000_0000;
               default: a = $urandom_range(0, 15) << 2;
            endcase
            ab = -1;
            if (WS_T[d] > 0 && $urandom_range(0, 7) == 0) ab = $urandom_range(0, WS_T[d] - 1);
            xfer(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                 ab, s, rd, e, lat);
         end
      end

      // Reset in the middle of a waiting write
      @(posedge clk); #1;
      psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
      paddr[2] = 32'h10; pwdata[2] = 32'h77777777; pstrb[2] = 4'hF;
      @(posedge clk); #1;
      penable[2] = 1'b1;
      #2;
      rst_n = 1'b0;
      psel[2] = 1'b0; penable[2] = 1'b0;
      clear_model();
      #1;
      chk("midrst_pready", 2, 32'(pready[2]), 32'd0);
      chk("midrst_prdata", 0, prdata[0], 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int d = 0; d < ND; d++) begin
         for (int w = 0; w < 16; w++) begin
            xfer(d, 1'b0, 32'(w * 4), 32'h0, 4'hF, -1, s, rd, e, lat);
            chk("post_rst_word", d, rd, 32'd0);
         end
      end

      @(posedge clk); #1;
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
